// File: rtl/rsa_uart_wrapper.sv
// ---------------------------------------------------------------------------
// rsa_uart_wrapper
//
// Avalon-MM master that connects the RS232 UART core to the RSA-256
// decryption core. After reset it receives the modulus n and the private
// exponent d, 32 bytes each and MSB first. It then loops forever:
//   - receive a 32-byte ciphertext y,
//   - pulse start to the core and wait for its finished pulse,
//   - send the low 31 bytes of the plaintext back over the UART, MSB first.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   avm_*                 Avalon-MM master towards the UART core
//   o_core_start          one-cycle start pulse to the decryption core
//   o_core_a/d/n          ciphertext, private exponent, modulus
//   i_core_result         plaintext from the core
//   i_core_finished       core-done pulse
// ---------------------------------------------------------------------------
module rsa_uart_wrapper #(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);

    typedef enum logic [2:0] {
        S_QUERY_RX,
        S_READ,
        S_START,
        S_WAIT_CALC,
        S_QUERY_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        LOAD_N,
        LOAD_D,
        LOAD_A
    } phase_t;

    state_t         state_q,  state_d;
    phase_t         phase_q,  phase_d;
    logic [255:0]   mod_q,    mod_d;
    logic [255:0]   exp_q,    exp_d;
    logic [255:0]   cipher_q, cipher_d;
    logic [255:0]   result_q, result_d;
    logic [4:0]     cnt_q,    cnt_d;
    logic [4:0]     addr_q,   addr_d;
    logic           read_q,   read_d;
    logic           write_q,  write_d;
    logic [31:0]    wdata_q,  wdata_d;

    logic           rd_done;
    logic           wr_done;
    logic [7:0]     rx_byte;
    logic           unused_bits;

    // A transfer completes only when the request is up and the slave does not stall.
    assign rd_done = read_q  & ~avm_waitrequest;
    assign wr_done = write_q & ~avm_waitrequest;
    assign rx_byte = avm_readdata[7:0];

    // Upper UART data bits and the top result byte never reach the serial link.
    assign unused_bits = ^{avm_readdata[31:8], result_q[255:248]};

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        cipher_d = cipher_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        read_d   = read_q;
        write_d  = write_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_QUERY_RX: begin
                if (rd_done && avm_readdata[RX_OK_BIT]) begin
                    read_d  = 1'b0;
                    addr_d  = RX_BASE;
                    state_d = S_READ;
                end else begin
                    read_d  = 1'b1;
                end
            end

            S_READ: begin
                if (rd_done) begin
                    // First byte received ends up as the MSB after 32 shifts.
                    case (phase_q)
                        LOAD_N:  mod_d    = {mod_q[247:0],    rx_byte};
                        LOAD_D:  exp_d    = {exp_q[247:0],    rx_byte};
                        default: cipher_d = {cipher_q[247:0], rx_byte};
                    endcase
                    cnt_d  = cnt_q + 5'd1;
                    addr_d = STATUS_BASE;
                    read_d = 1'b1;
                    state_d = S_QUERY_RX;
                    if (cnt_q == 5'd31) begin
                        case (phase_q)
                            LOAD_N:  phase_d = LOAD_D;
                            LOAD_D:  phase_d = LOAD_A;
                            default: begin
                                phase_d = LOAD_A;
                                read_d  = 1'b0;
                                state_d = S_START;
                            end
                        endcase
                    end
                end else begin
                    read_d = 1'b1;
                end
            end

            S_START: begin
                state_d = S_WAIT_CALC;
            end

            S_WAIT_CALC: begin
                if (i_core_finished) begin
                    result_d = i_core_result;
                    cnt_d    = 5'd0;
                    addr_d   = STATUS_BASE;
                    read_d   = 1'b1;
                    state_d  = S_QUERY_TX;
                end
            end

            S_QUERY_TX: begin
                if (rd_done && avm_readdata[TX_OK_BIT]) begin
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    addr_d  = TX_BASE;
                    wdata_d = {24'd0, result_q[247:240]};
                    state_d = S_WRITE;
                end else begin
                    read_d  = 1'b1;
                end
            end

            S_WRITE: begin
                if (wr_done) begin
                    write_d  = 1'b0;
                    result_d = {result_q[247:0], 8'd0};
                    addr_d   = STATUS_BASE;
                    read_d   = 1'b1;
                    // Only 31 bytes of plaintext are meaningful.
                    if (cnt_q == 5'd30) begin
                        cnt_d   = 5'd0;
                        state_d = S_QUERY_RX;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = S_QUERY_TX;
                    end
                end
            end

            default: begin
                state_d = S_QUERY_RX;
                addr_d  = STATUS_BASE;
                read_d  = 1'b1;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_QUERY_RX;
            phase_q  <= LOAD_N;
            mod_q    <= '0;
            exp_q    <= '0;
            cipher_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            addr_q   <= STATUS_BASE;
            read_q   <= 1'b1;
            write_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            cipher_q <= cipher_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign o_core_start  = (state_q == S_START);
    assign o_core_a      = cipher_q;
    assign o_core_d      = exp_q;
    assign o_core_n      = mod_q;

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
`timescale 1ns/1ps
module tb_rsa_uart_wrapper;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata = '0;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest = 1'b0;
    logic         o_core_start;
    logic [255:0] o_core_a, o_core_d, o_core_n;
    logic [255:0] i_core_result;
    logic         i_core_finished;

    always #5 clk = ~clk;

    rsa_uart_wrapper dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_core_start    (o_core_start),
        .o_core_a        (o_core_a),
        .o_core_d        (o_core_d),
        .o_core_n        (o_core_n),
        .i_core_result   (i_core_result),
        .i_core_finished (i_core_finished)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // UART slave model: byte queues, random status flags, optional stalls
    // ------------------------------------------------------------------
    byte unsigned rx_q[$];
    byte unsigned tx_q[$];
    bit           stall_mode = 1'b0;
    int           stall_cnt = 0;
    int           status_reads = 0;
    int           rx_reads = 0;
    int           starts = 0;
    bit           first_seen = 1'b0;
    logic [4:0]   first_addr = '0;
    logic         first_rd = 1'b0;
    logic [31:0]  last_status = '0;
    bit           last_was_status = 1'b0;
    logic [38:0]  snap;
    logic [31:0]  r;
    bit           s_hold;
    bit           rx_ok, tx_ok;
    byte unsigned b;

    always @(negedge clk) begin
        if (!i_rst) begin
            avm_waitrequest = 1'b0;
            stall_cnt       = 0;
            last_was_status = 1'b0;
        end else begin
            if (o_core_start) starts++;
            if (avm_read || avm_write) begin
                s_hold = 1'b0;
                if (stall_mode && (avm_write || avm_address == 5'd0))
                    s_hold = (stall_cnt < 4);
                else if (avm_address == 5'd8 && $urandom_range(0, 3) == 0)
                    s_hold = 1'b1;
                if (stall_cnt > 0)
                    check("hold_stable", {avm_address, avm_read, avm_write, avm_writedata}, snap);
                if (s_hold) begin
                    avm_waitrequest = 1'b1;
                    if (stall_cnt == 0) snap = {avm_address, avm_read, avm_write, avm_writedata};
                    stall_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                    r = $urandom();
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_addr = avm_address;
                        first_rd   = avm_read;
                    end
                    if (avm_read && !avm_write && avm_address == 5'd8) begin
                        rx_ok = (rx_q.size() > 0) && ($urandom_range(0, 3) != 0);
                        tx_ok = $urandom_range(0, 1);
                        avm_readdata = (r & 32'hFFFF_FF3F) | (32'(rx_ok) << 7) | (32'(tx_ok) << 6);
                        last_status = avm_readdata;
                        last_was_status = 1'b1;
                        status_reads++;
                    end else if (avm_read && !avm_write && avm_address == 5'd0) begin
                        check("rx_after_ok", 256'(last_was_status && last_status[7] && rx_q.size() > 0), 256'd1);
                        b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
                        avm_readdata = (r & 32'hFFFF_FF00) | 32'(b);
                        rx_reads++;
                        last_was_status = 1'b0;
                    end else if (avm_write && !avm_read && avm_address == 5'd4) begin
                        check("tx_after_ok", 256'(last_was_status && last_status[6]), 256'd1);
                        check("tx_upper_zero", 256'(avm_writedata[31:8]), 256'd0);
                        tx_q.push_back(avm_writedata[7:0]);
                        last_was_status = 1'b0;
                    end else begin
                        check("bad_access", {avm_read, avm_write, avm_address}, 256'd0);
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model helpers
    // ------------------------------------------------------------------
    function automatic logic [255:0] rand256();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | 256'($urandom());
        return v;
    endfunction

    task automatic push_val(input logic [255:0] v);
        for (int i = 0; i < 32; i++)
            rx_q.push_back(8'((v >> (8 * (31 - i))) & 256'hFF));
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_core_finished = 1'b0;
        repeat (3) @(negedge clk);
        stall_mode = 1'b0;
        rx_q.delete();
        tx_q.delete();
        @(negedge clk);
        i_rst = 1'b1;
    endtask

    typedef struct {
        bit           rst_before;
        bit           reload;
        bit           stall;
        logic [255:0] n, d, a, res;
        logic [255:0] exp_n, exp_d, exp_a;
        logic [247:0] exp_tx;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int s0;
        bit seen, stable;
        logic [767:0] snapshot;
        logic [247:0] got;
        if (v.rst_before) do_reset();
        stall_mode = v.stall;
        if (v.reload) begin
            push_val(v.n);
            push_val(v.d);
        end
        push_val(v.a);
        s0 = starts;
        seen = 1'b0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge clk);
            if (o_core_start) seen = 1'b1;
        end
        check($sformatf("start_seen[%0d]", idx), 256'(seen), 256'd1);
        if (!seen) return;
        check($sformatf("core_n[%0d]", idx), o_core_n, v.exp_n);
        check($sformatf("core_d[%0d]", idx), o_core_d, v.exp_d);
        check($sformatf("core_a[%0d]", idx), o_core_a, v.exp_a);
        // A finished pulse coinciding with start carries a bogus result.
        snapshot = {o_core_a, o_core_d, o_core_n};
        i_core_finished = 1'b1;
        i_core_result = ~v.res;
        @(negedge clk);
        i_core_finished = 1'b0;
        stable = 1'b1;
        repeat (199) begin
            @(negedge clk);
            if ({o_core_a, o_core_d, o_core_n} !== snapshot) stable = 1'b0;
        end
        check($sformatf("ops_stable[%0d]", idx), 256'(stable), 256'd1);
        i_core_finished = 1'b1;
        i_core_result = v.res;
        @(negedge clk);
        i_core_finished = 1'b0;
        i_core_result = rand256();
        for (int k = 0; k < 20000 && tx_q.size() < 31; k++) @(negedge clk);
        repeat (60) @(negedge clk);
        check($sformatf("tx_count[%0d]", idx), 256'(tx_q.size()), 256'd31);
        got = '0;
        for (int k = 0; k < tx_q.size() && k < 31; k++) got = (got << 8) | 248'(tx_q[k]);
        check($sformatf("tx_data[%0d]", idx), 256'(got), 256'(v.exp_tx));
        check($sformatf("start_count[%0d]", idx), 256'(starts - s0), 256'd1);
        tx_q.delete();
    endtask

    initial begin
        logic [255:0] base_n, base_d, base_res, cur_n, cur_d;
        int s_mid;
        bit seen;

        // Table set-up: plan values for entries 0 and 2, random otherwise.
        base_n = '0;
        for (int k = 0; k < 32; k++) base_n = (base_n << 8) | 256'(k + 1);
        base_d = {32{8'hAA}};
        base_res = '0;
        for (int k = 0; k < 31; k++) base_res = (base_res << 8) | 256'(((k + 1) * 17) % 256);

        vecs[0] = '{0, 1, 0, base_n, base_d, 256'h5, base_res, '0, '0, '0, '0};
        vecs[1] = '{0, 0, 0, '0, '0, rand256(), rand256(), '0, '0, '0, '0};
        vecs[2] = '{1, 1, 1, base_n, base_d, 256'h5, base_res, '0, '0, '0, '0};
        vecs[3] = '{0, 0, 1, '0, '0, rand256(), rand256(), '0, '0, '0, '0};
        vecs[4] = '{0, 1, 0, rand256(), rand256(), rand256(), rand256(), '0, '0, '0, '0};
        vecs[5] = '{0, 0, 1'($urandom_range(0, 1)), '0, '0, rand256(), rand256(), '0, '0, '0, '0};

        // Model: n/d persist until reloaded; plaintext is result mod 2^248.
        cur_n = '0;
        cur_d = '0;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].reload) begin
                cur_n = vecs[i].n;
                cur_d = vecs[i].d;
            end
            vecs[i].exp_n  = cur_n;
            vecs[i].exp_d  = cur_d;
            vecs[i].exp_a  = vecs[i].a;
            vecs[i].exp_tx = 248'(vecs[i].res % (256'd1 << 248));
        end

        // Reset values.
        i_rst = 1'b0;
        i_core_finished = 1'b0;
        i_core_result = '0;
        repeat (3) @(negedge clk);
        check("rst_addr",   256'(avm_address),   256'd8);
        check("rst_read",   256'(avm_read),      256'd1);
        check("rst_write",  256'(avm_write),     256'd0);
        check("rst_wdata",  256'(avm_writedata), 256'd0);
        check("rst_start",  256'(o_core_start),  256'd0);
        check("rst_a",      o_core_a,            256'd0);
        check("rst_d",      o_core_d,            256'd0);
        check("rst_n",      o_core_n,            256'd0);
        status_reads = 0;
        rx_reads = 0;
        first_seen = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;

        // Polls with no RX data available.
        for (int k = 0; k < 200 && status_reads < 5; k++) @(negedge clk);
        check("poll_count", 256'(status_reads >= 5), 256'd1);
        check("no_rx_read", 256'(rx_reads), 256'd0);
        check("first_addr", 256'(first_addr), 256'd8);
        check("first_rd",   256'(first_rd),   256'd1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Reset while the core is computing; a late finished must be ignored.
        do_reset();
        push_val(rand256());
        push_val(rand256());
        push_val(rand256());
        seen = 1'b0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge clk);
            if (o_core_start) seen = 1'b1;
        end
        check("mid_start_seen", 256'(seen), 256'd1);
        repeat (50) @(negedge clk);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_n",    o_core_n, 256'd0);
        check("mid_rst_a",    o_core_a, 256'd0);
        check("mid_rst_read", 256'(avm_read), 256'd1);
        rx_q.delete();
        tx_q.delete();
        @(negedge clk);
        i_rst = 1'b1;
        s_mid = starts;
        @(negedge clk);
        i_core_finished = 1'b1;
        i_core_result = rand256();
        @(negedge clk);
        i_core_finished = 1'b0;
        repeat (100) @(negedge clk);
        check("stale_no_tx",    256'(tx_q.size()), 256'd0);
        check("stale_no_start", 256'(starts - s_mid), 256'd0);
        check("stale_n_zero",   o_core_n, 256'd0);

        for (int i = 4; i < 6; i++) run_vec(vecs[i], i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_uart_wrapper.md
Name: rsa_uart_wrapper

Overview:
- Avalon-MM master that bridges the board's RS232 UART core and the external RSA-256 decryption core.
- Loads the key pair (n, d) from the serial link, then loops forever:
  - receives a 256-bit ciphertext block,
  - pulses start to the decryption core and waits for its finish,
  - transmits the 248-bit plaintext back over the UART.
- Sits directly upstream and downstream of the decryption core; it is the core's only source of operands and only consumer of results.

Parameters:
- RX_BASE, 5'd0, UART RX data register address (data in bits [7:0]).
- TX_BASE, 5'd4, UART TX data register address (data in bits [7:0]).
- STATUS_BASE, 5'd8, UART status register address.
- RX_OK_BIT, 7, status bit meaning an RX byte is available.
- TX_OK_BIT, 6, status bit meaning the TX holding register is free.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-low
- avm_address  out  5  Avalon address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data
- avm_waitrequest  in  1  Avalon stall
- o_core_start  out  1  one-cycle start pulse to the decryption core
- o_core_a  out  256  ciphertext y
- o_core_d  out  256  private exponent d
- o_core_n  out  256  modulus n
- i_core_result  in  256  plaintext x from the core
- i_core_finished  in  1  core-done pulse

Behaviour:
- Reset (i_rst low, asynchronous):
  - All outputs are 0, except avm_address = STATUS_BASE and avm_read = 1.
  - n, d, a and result registers are 0; byte counter is 0; phase = LOAD_N; state = S_QUERY_RX.
- Avalon rule: a transfer completes only in a cycle where the request is high and avm_waitrequest is low. The request, address and writedata are held stable until completion. Only one request is high at a time.
- State S_QUERY_RX: read STATUS_BASE.
  - On completion with readdata[RX_OK_BIT]=1: drop avm_read, set address to RX_BASE, go to S_READ.
  - Otherwise keep polling: avm_read stays high and the read is re-issued.
- State S_READ: read RX_BASE. On completion, shift the byte into the target register for the current phase: target <= {target[247:0], readdata[7:0]}. The first byte received therefore ends up as the MSB.
  - byte counter += 1; it wraps to 0 after 31.
  - After the 32nd byte (counter was 31), advance the phase:
    - LOAD_N -> LOAD_D;
    - LOAD_D -> LOAD_A;
    - LOAD_A -> the block goes to S_START instead of polling again.
  - Otherwise return to S_QUERY_RX.
- State S_START: o_core_start = 1 for exactly one cycle; o_core_a/d/n are already stable. Next state is S_WAIT_CALC.
- State S_WAIT_CALC: no Avalon traffic.
  - When i_core_finished = 1, latch i_core_result, set byte counter = 0, go to S_QUERY_TX.
  - A finished pulse in the same cycle as start, or in any other state, is ignored.
- State S_QUERY_TX: read STATUS_BASE.
  - On completion with readdata[TX_OK_BIT]=1: go to S_WRITE with address TX_BASE and writedata = {24'd0, result[247:240]}.
  - Otherwise keep polling.
- State S_WRITE: hold avm_write until completion, then shift the result left by 8 and increment the counter.
  - After 31 bytes: counter = 0, phase stays LOAD_A (n and d are retained), go to S_QUERY_RX for the next ciphertext.
  - Otherwise return to S_QUERY_TX.
  - Exactly 31 bytes, result[247:0], are sent MSB-first. result[255:248] is discarded; it is 0 for any n < 2^248.
- o_core_a, o_core_d and o_core_n are continuous views of the internal registers. They may change while bytes are being received, but never between o_core_start and i_core_finished.
- avm_waitrequest held high indefinitely: the FSM stalls with its request held, and no byte is lost or duplicated.
- Reset mid-operation (any state): the block returns to the reset values and the next received byte is treated as byte 0 of n.

Test Plan:
1. Reset low for 3 cycles, then high → outputs match the reset values; first transaction is a read of address 8. Status returns 0x00 for 5 polls → no RX read is issued during those polls.
2. Feed 32 bytes 0x01..0x20 for n, 32 bytes of 0xAA for d, and 32 bytes of 0x00 except a last byte 0x05 for y:
   - o_core_n = 0x0102…20;
   - o_core_d = all 0xAA;
   - o_core_a = 0x…05;
   - exactly one o_core_start pulse.
3. Core model returns result 0x00_1122…(31 bytes) with i_core_finished two hundred cycles later → 31 writes to address 4 carrying 0x11, 0x22, … in order; each write is preceded by a status read with bit6 = 1.
4. avm_waitrequest high for 4 cycles on every RX read and TX write → same byte sequences as scenarios 2–3, with request and address held stable during each stall.
5. Second ciphertext after the first result → no n/d reload; 32 bytes go straight to o_core_a; second start pulse; correct second output.
6. Pull i_rst low in the middle of S_WAIT_CALC, then release; send a fresh n/d/y sequence → correct results. A stale i_core_finished arriving after reset is ignored.
